// File: rtl/atm_txn_ctrl.sv
// ---------------------------------------------------------------------------
// atm_txn_ctrl
//
// Purpose:
//   Transaction controller that sits behind the unlock FSM. While locked it
//   ignores requests. When the unlock stage grants a session it serves one
//   request at a time (balance query, deposit, withdraw, logout) against a
//   balance register that persists across sessions. A session closes on
//   logout, after MAX_TXN counted transactions, or after TIMEOUT idle cycles.
//
// Ports:
//   clk             system clock, rising edge
//   rst             asynchronous active-high reset
//   unlock          session grant from the unlock stage (level)
//   req_valid       request present
//   req_op          00 balance, 01 deposit, 10 withdraw, 11 logout
//   req_amt         amount for deposit/withdraw
//   req_ready       request accepted this cycle when high with req_valid
//   rsp_valid       one-cycle response strobe
//   rsp_ok          request executed (held between strobes)
//   rsp_err         00 none, 01 insufficient, 10 overflow, 11 zero amount
//   balance         current balance
//   session_active  high while a session is open
// ---------------------------------------------------------------------------
module atm_txn_ctrl #(
   parameter int BAL_W    = 16,
   parameter int AMT_W    = 12,
   parameter int INIT_BAL = 1000,
   parameter int MAX_TXN  = 4,
   parameter int TIMEOUT  = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             unlock,
   input  logic             req_valid,
   input  logic [1:0]       req_op,
   input  logic [AMT_W-1:0] req_amt,
   output logic             req_ready,
   output logic             rsp_valid,
   output logic             rsp_ok,
   output logic [1:0]       rsp_err,
   output logic [BAL_W-1:0] balance,
   output logic             session_active
);

   localparam int TXN_W  = $clog2(MAX_TXN + 1);
   localparam int IDLE_W = $clog2(TIMEOUT + 1);

   localparam logic [1:0] OP_BAL    = 2'b00;
   localparam logic [1:0] OP_DEP    = 2'b01;
   localparam logic [1:0] OP_WDR    = 2'b10;
   localparam logic [1:0] OP_LOGOUT = 2'b11;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_INSUF = 2'b01;
   localparam logic [1:0] ERR_OVFL  = 2'b10;
   localparam logic [1:0] ERR_ZERO  = 2'b11;

   typedef enum logic [1:0] {
      S_LOCKED,
      S_IDLE,
      S_EXEC,
      S_RESP
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic               armed;
   logic [TXN_W-1:0]   txn_cnt;
   logic [TXN_W-1:0]   txn_after;
   logic [IDLE_W-1:0]  idle_cnt;
   logic [1:0]         op_q;
   logic [AMT_W-1:0]   amt_q;
   logic [BAL_W-1:0]   amt_ext;
   logic [BAL_W:0]     dep_sum;
   logic               exec_ok;
   logic [1:0]         exec_err;
   logic [BAL_W-1:0]   exec_bal;
   logic               idle_expired;
   logic               txn_limit;

   // Deposit sum is one bit wider than the balance so an overflow shows up
   // as the carry bit instead of silently wrapping.
   assign amt_ext = BAL_W'(amt_q);
   assign dep_sum = {1'b0, balance} + {1'b0, amt_ext};

   // Logout is the only op that does not count toward the session limit.
   assign txn_after    = txn_cnt + ((op_q != OP_LOGOUT) ? TXN_W'(1) : TXN_W'(0));
   assign txn_limit    = (txn_after == TXN_W'(MAX_TXN));
   assign idle_expired = (idle_cnt == IDLE_W'(TIMEOUT - 1));

   // Evaluate the captured request against the current balance. The result
   // is committed to the balance/response registers at the end of EXEC so
   // it is visible during the RESP cycle.
   always_comb begin
      exec_ok  = 1'b1;
      exec_err = ERR_NONE;
      exec_bal = balance;
      case (op_q)
         OP_DEP: begin
            if (amt_q == '0) begin
               exec_ok  = 1'b0;
               exec_err = ERR_ZERO;
            end else if (dep_sum[BAL_W]) begin
               exec_ok  = 1'b0;
               exec_err = ERR_OVFL;
            end else begin
               exec_bal = dep_sum[BAL_W-1:0];
            end
         end
         OP_WDR: begin
            if (amt_q == '0) begin
               exec_ok  = 1'b0;
               exec_err = ERR_ZERO;
            end else if (amt_ext > balance) begin
               exec_ok  = 1'b0;
               exec_err = ERR_INSUF;
            end else begin
               exec_bal = balance - amt_ext;
            end
         end
         default: begin
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_LOCKED;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic. In IDLE a request beats the timeout on the same
   // cycle; unlock only matters while locked and must have been re-armed.
   always_comb begin
      state_nxt = state;
      case (state)
         S_LOCKED: if (unlock && armed) state_nxt = S_IDLE;
         S_IDLE: begin
            if (req_valid)         state_nxt = S_EXEC;
            else if (idle_expired) state_nxt = S_LOCKED;
         end
         S_EXEC: state_nxt = S_RESP;
         S_RESP: begin
            if ((op_q == OP_LOGOUT) || txn_limit) state_nxt = S_LOCKED;
            else                                  state_nxt = S_IDLE;
         end
         default: state_nxt = S_LOCKED;
      endcase
   end

   // Outputs decoded purely from the state register.
   always_comb begin
      req_ready      = (state == S_IDLE);
      rsp_valid      = (state == S_RESP);
      session_active = (state != S_LOCKED);
   end

   // Session bookkeeping: the arm flag forces unlock to fall before another
   // session can open, and the counters restart whenever a session opens.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         armed    <= 1'b1;
         txn_cnt  <= '0;
         idle_cnt <= '0;
      end else begin
         case (state)
            S_LOCKED: begin
               if (!unlock) begin
                  armed <= 1'b1;
               end else if (armed) begin
                  armed    <= 1'b0;
                  txn_cnt  <= '0;
                  idle_cnt <= '0;
               end
            end
            S_IDLE: begin
               if (req_valid) idle_cnt <= '0;
               else           idle_cnt <= idle_cnt + IDLE_W'(1);
            end
            S_RESP: txn_cnt <= txn_after;
            default: begin
            end
         endcase
      end
   end

   // Datapath: capture the request on the handshake, commit the evaluated
   // result on leaving EXEC. rsp_ok/rsp_err keep their value between strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q    <= OP_BAL;
         amt_q   <= '0;
         balance <= BAL_W'(INIT_BAL);
         rsp_ok  <= 1'b0;
         rsp_err <= ERR_NONE;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  op_q  <= req_op;
                  amt_q <= req_amt;
               end
            end
            S_EXEC: begin
               balance <= exec_bal;
               rsp_ok  <= exec_ok;
               rsp_err <= exec_err;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_atm_txn_ctrl.sv
// ---------------------------------------------------------------------------
// tb_atm_txn_ctrl
//
// Purpose:
//   Drives atm_txn_ctrl with directed and randomized sessions. The driver
//   predicts each response from a plain-arithmetic account model and queues
//   it; a monitor on the falling edge pops and compares whenever rsp_valid
//   is high, including the cycle the response is due.
// ---------------------------------------------------------------------------
module tb_atm_txn_ctrl;

   localparam int BAL_W    = 16;
   localparam int AMT_W    = 12;
   localparam int INIT_BAL = 65000;
   localparam int MAX_TXN  = 4;
   localparam int TIMEOUT  = 16;
   localparam int BAL_MAX  = (1 << BAL_W) - 1;
   localparam int AMT_MAX  = (1 << AMT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             unlock = 1'b0;
   logic             req_valid = 1'b0;
   logic [1:0]       req_op = 2'b00;
   logic [AMT_W-1:0] req_amt = '0;
   logic             req_ready;
   logic             rsp_valid;
   logic             rsp_ok;
   logic [1:0]       rsp_err;
   logic [BAL_W-1:0] balance;
   logic             session_active;

   typedef struct {
      int cyc;
      bit ok;
      int err;
      int bal;
   } exp_t;

   exp_t expq[$];
   int   checks = 0;
   int   failures = 0;
   int   cycle = 0;
   int   model_bal = INIT_BAL;
   int   model_txn = 0;
   bit   session_closed = 1'b1;

   atm_txn_ctrl #(
      .BAL_W(BAL_W), .AMT_W(AMT_W), .INIT_BAL(INIT_BAL),
      .MAX_TXN(MAX_TXN), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .unlock(unlock),
      .req_valid(req_valid), .req_op(req_op), .req_amt(req_amt),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ok(rsp_ok),
      .rsp_err(rsp_err), .balance(balance), .session_active(session_active)
   );

   // 10-unit clock; the cycle index lets the monitor check response latency.
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Single comparison point: every check funnels through here.
   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Account model: applies the op rules to an integer balance.
   task automatic predict(input int op, input int amt, output bit ok, output int err);
      ok  = 1'b1;
      err = 0;
      if (op == 1) begin
         if (amt == 0)                      begin ok = 1'b0; err = 3; end
         else if (model_bal + amt > BAL_MAX) begin ok = 1'b0; err = 2; end
         else                               model_bal = model_bal + amt;
      end else if (op == 2) begin
         if (amt == 0)               begin ok = 1'b0; err = 3; end
         else if (amt > model_bal)   begin ok = 1'b0; err = 1; end
         else                        model_bal = model_bal - amt;
      end
   endtask

   // Monitor: flags overdue responses, unexpected strobes, and compares
   // each strobe against the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         while (expq.size() > 0 && expq[0].cyc < cycle) begin
            checkOutput("rsp_valid_missing", 0, 1);
            void'(expq.pop_front());
         end
         if (rsp_valid) begin
            if (expq.size() == 0) begin
               checkOutput("rsp_valid_unexpected", 1, 0);
            end else begin
               e = expq.pop_front();
               checkOutput("rsp_cycle", cycle, e.cyc);
               checkOutput("rsp_ok", int'(rsp_ok), int'(e.ok));
               checkOutput("rsp_err", int'(rsp_err), e.err);
               checkOutput("rsp_balance", int'(balance), e.bal);
            end
         end
      end
   end

   // Opens a session from LOCKED: unlock low for a cycle to re-arm, then
   // high for a cycle. With hold set, unlock stays high afterwards.
   task automatic openSession(input bit hold);
      unlock = 1'b0;
      @(posedge clk); #1;
      unlock = 1'b1;
      @(posedge clk); #1;
      if (!hold) unlock = 1'b0;
      checkOutput("session_open_active", int'(session_active), 1);
      checkOutput("session_open_ready", int'(req_ready), 1);
      model_txn      = 0;
      session_closed = 1'b0;
   endtask

   // Presents one request after pre_wait cycles, waits (bounded) for
   // req_ready, queues the predicted response due two cycles after accept.
   task automatic applyStimulus(input int op, input int amt, input int pre_wait);
      int   waited;
      bit   ok;
      int   err;
      exp_t e;
      repeat (pre_wait) begin @(posedge clk); #1; end
      req_valid = 1'b1;
      req_op    = 2'(op);
      req_amt   = AMT_W'(amt);
      waited    = 0;
      while (!req_ready && waited < 4) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!req_ready) begin
         checkOutput("req_ready_wait", 0, 1);
         req_valid = 1'b0;
         return;
      end
      predict(op, amt, ok, err);
      e.cyc = cycle + 2;
      e.ok  = ok;
      e.err = err;
      e.bal = model_bal;
      expq.push_back(e);
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_op    = 2'($urandom);
      req_amt   = AMT_W'($urandom);
      if (op != 3) model_txn++;
      session_closed = (op == 3) || (model_txn == MAX_TXN);
   endtask

   // Issues one op with a random gap that never exceeds the idle limit.
   // Follow-up ops may be presented early, while the controller is busy.
   task automatic doOp(input int op, input int amt, input bit first);
      int k;
      k = int'($urandom_range(0, TIMEOUT - 1));
      if (first)                           applyStimulus(op, amt, k);
      else if ($urandom_range(0, 2) == 0)  applyStimulus(op, amt, 0);
      else                                 applyStimulus(op, amt, 2 + k);
   endtask

   // Called right after the last accept: the session must be closed once
   // its response has gone out, and stay closed while unlock is held.
   task automatic closeCheck(input bit hold);
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("closed_active", int'(session_active), 0);
      checkOutput("closed_ready", int'(req_ready), 0);
      if (hold) begin
         repeat (3) begin @(posedge clk); #1; end
         checkOutput("held_unlock_locked", int'(session_active), 0);
      end
      unlock = 1'b0;
   endtask

   function automatic int pickAmt(input int op);
      int r;
      r = int'($urandom_range(0, 9));
      if (op == 0 || op == 3) return int'($urandom_range(0, AMT_MAX));
      if (r == 0) return 0;
      if (r == 1) return (model_bal <= AMT_MAX && model_bal > 0) ? model_bal : AMT_MAX;
      if (r == 2) return AMT_MAX;
      return int'($urandom_range(1, AMT_MAX));
   endfunction

   function automatic int pickOp();
      int r;
      r = int'($urandom_range(0, 15));
      if (r == 0) return 3;
      if (r <= 4) return 0;
      if (r <= 9) return 1;
      return 2;
   endfunction

   // Hard stop if the run ever stalls.
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence.
   initial begin
      bit hold;
      int op;
      bit first;

      #2 rst = 1'b1;
      #2;
      checkOutput("reset_req_ready", int'(req_ready), 0);
      checkOutput("reset_rsp_valid", int'(rsp_valid), 0);
      checkOutput("reset_rsp_ok", int'(rsp_ok), 0);
      checkOutput("reset_rsp_err", int'(rsp_err), 0);
      checkOutput("reset_balance", int'(balance), INIT_BAL);
      checkOutput("reset_session", int'(session_active), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      $display("[TB] balance query and overflow boundary");
      openSession(1'b0);
      doOp(0, 0, 1'b1);
      doOp(1, 600, 1'b0);
      doOp(1, 535, 1'b0);
      doOp(2, 0, 1'b0);
      closeCheck(1'b0);
      checkOutput("balance_at_max", int'(balance), 65535);

      $display("[TB] drain with full-size withdrawals");
      for (int s = 0; s < 4; s++) begin
         hold = s[0];
         openSession(hold);
         for (int i = 0; i < MAX_TXN; i++) doOp(2, AMT_MAX, i == 0);
         closeCheck(hold);
      end
      checkOutput("balance_drained", int'(balance), 15);

      openSession(1'b1);
      doOp(2, 15, 1'b1);
      doOp(2, 1, 1'b0);
      doOp(1, 0, 1'b0);
      doOp(0, 0, 1'b0);
      closeCheck(1'b1);
      checkOutput("balance_zero", int'(balance), 0);

      $display("[TB] withdraw within and beyond balance, then logout");
      openSession(1'b0);
      doOp(1, 1000, 1'b1);
      doOp(2, 300, 1'b0);
      doOp(2, 800, 1'b0);
      doOp(3, 0, 1'b0);
      closeCheck(1'b0);
      checkOutput("balance_after_logout", int'(balance), 700);

      $display("[TB] idle timeout");
      openSession(1'b0);
      repeat (TIMEOUT - 1) begin @(posedge clk); #1; end
      checkOutput("timeout_last_cycle_active", int'(session_active), 1);
      @(posedge clk); #1;
      checkOutput("timeout_locked", int'(session_active), 0);
      checkOutput("timeout_ready", int'(req_ready), 0);
      req_valid = 1'b1;
      req_op    = 2'b00;
      repeat (5) begin
         @(posedge clk); #1;
         checkOutput("locked_req_ready", int'(req_ready), 0);
      end
      req_valid = 1'b0;

      $display("[TB] reset during execute");
      openSession(1'b0);
      doOp(0, 0, 1'b1);
      repeat (2) begin @(posedge clk); #1; end
      req_valid = 1'b1;
      req_op    = 2'b10;
      req_amt   = AMT_W'(100);
      @(posedge clk); #1;
      req_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      checkOutput("midexec_reset_session", int'(session_active), 0);
      checkOutput("midexec_reset_balance", int'(balance), INIT_BAL);
      checkOutput("midexec_reset_rsp_valid", int'(rsp_valid), 0);
      expq.delete();
      model_bal = INIT_BAL;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         checkOutput("after_reset_rsp_valid", int'(rsp_valid), 0);
      end

      $display("[TB] randomized sessions");
      for (int s = 0; s < 30; s++) begin
         hold = 1'($urandom_range(0, 1));
         openSession(hold);
         first = 1'b1;
         while (!session_closed) begin
            op = pickOp();
            doOp(op, pickAmt(op), first);
            first = 1'b0;
         end
         closeCheck(hold);
      end

      repeat (4) begin @(posedge clk); #1; end
      checkOutput("scoreboard_drained", expq.size(), 0);
      checkOutput("final_balance", int'(balance), model_bal);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
